// File: rtl/shift_cmd_sequencer_pkg.sv
// Shared definitions for the shift command sequencer: op encodings that
// match the downstream {s1,s0} mode selects, and the controller states.
package shift_cmd_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_cmd_sequencer_if.sv
// Command channel into the shift command sequencer.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. The issuer must hold cmd_valid and the cmd_op /
// cmd_cnt / cmd_data fields stable until that edge; while cmd_ready is low
// the command is not consumed. cmd_ready never depends on cmd_valid.
interface shift_cmd_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_cnt,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_cnt,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/shift_cmd_sequencer_bitbuf.sv
// Loadable rotate buffer holding the LOAD word or the serial fill pattern.
// It exposes its next value so the sequencer can register the bit that
// the downstream register will consume in the following cycle.
module shift_cmd_bitbuf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             rot_r,
    input  logic             rot_l,
    output logic [WIDTH-1:0] data_next,
    output logic             lsb_next,
    output logic             msb_next
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next buffer value: load wins, otherwise rotate one place or hold.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (rot_r) begin
            data_d = {data_q[0], data_q[WIDTH-1:1]};
        end else if (rot_l) begin
            data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        end
    end

    // Buffer register, cleared by reset so an abandoned command leaves nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_next = data_d;
    assign lsb_next  = data_d[0];
    assign msb_next  = data_d[WIDTH-1];

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Command-driven controller for a universal shift register. Each accepted
// command becomes a sequence of registered {s1,s0}/I_par/serial-bit
// cycles, followed by a one-cycle done pulse.
module shift_cmd_sequencer
    import shift_cmd_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_cmd_sequencer_if.slave  cmd,
    output logic                  s1,
    output logic                  s0,
    output logic [WIDTH-1:0]      I_par,
    output logic                  MSB_in,
    output logic                  LSB_in,
    output logic                  busy,
    output logic                  done,
    output state_t                state_dbg
);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic [1:0]       s_q, s_d;
    logic [WIDTH-1:0] i_par_q, i_par_d;
    logic             msb_in_q, msb_in_d;
    logic             lsb_in_q, lsb_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cmd_ready_q, cmd_ready_d;

    logic             buf_load, buf_rot_r, buf_rot_l;
    logic [WIDTH-1:0] buf_next;
    logic             buf_lsb_next, buf_msb_next;
    logic             accept;
    logic             is_shift;

    shift_cmd_bitbuf #(.WIDTH(WIDTH)) u_bitbuf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .load_data (cmd.cmd_data),
        .rot_r     (buf_rot_r),
        .rot_l     (buf_rot_l),
        .data_next (buf_next),
        .lsb_next  (buf_lsb_next),
        .msb_next  (buf_msb_next)
    );

    // Next-state logic: accept in IDLE, count down actions in RUN, one DONE cycle.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rem_d     = rem_q;
        buf_load  = 1'b0;
        buf_rot_r = 1'b0;
        buf_rot_l = 1'b0;
        accept    = cmd.cmd_valid && cmd_ready_q && (state_q == ST_IDLE);
        is_shift  = (cmd.cmd_op == OP_SHR) || (cmd.cmd_op == OP_SHL);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    buf_load = 1'b1;
                    op_d     = cmd.cmd_op;
                    if (cmd.cmd_op == OP_LOAD) begin
                        rem_d = CNT_W'(1);
                    end else if (is_shift) begin
                        rem_d = cmd.cmd_cnt;
                    end else begin
                        rem_d = '0;
                    end
                    if ((cmd.cmd_op == OP_NOP) || (is_shift && (cmd.cmd_cnt == '0))) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                buf_rot_r = (op_q == OP_SHR);
                buf_rot_l = (op_q == OP_SHL);
                rem_d     = rem_q - CNT_W'(1);
                if (rem_q <= CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so every output is a flop.
    always_comb begin
        s_d         = 2'b00;
        i_par_d     = '0;
        msb_in_d    = 1'b0;
        lsb_in_d    = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        cmd_ready_d = (state_d == ST_IDLE);
        if (state_d == ST_RUN) begin
            s_d      = op_d;
            i_par_d  = (op_d == OP_LOAD) ? buf_next : '0;
            msb_in_d = (op_d == OP_SHR) && buf_lsb_next;
            lsb_in_d = (op_d == OP_SHL) && buf_msb_next;
        end
    end

    // State and output registers; reset abandons any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            rem_q       <= '0;
            s_q         <= 2'b00;
            i_par_q     <= '0;
            msb_in_q    <= 1'b0;
            lsb_in_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rem_q       <= rem_d;
            s_q         <= s_d;
            i_par_q     <= i_par_d;
            msb_in_q    <= msb_in_d;
            lsb_in_q    <= lsb_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd.cmd_ready = cmd_ready_q;
    assign s1            = s_q[1];
    assign s0            = s_q[0];
    assign I_par         = i_par_q;
    assign MSB_in        = msb_in_q;
    assign LSB_in        = lsb_in_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer driving a 4-bit universal shift register.
module tb_shift_cmd_sequencer;
    import shift_cmd_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       s1, s0, msb_in, lsb_in, busy, done;
    logic [3:0] i_par;
    state_t     state_dbg;
    logic [3:0] a_q = 4'b0000;

    int n_checks = 0;
    int n_pass   = 0;

    shift_cmd_sequencer_if #(.WIDTH(4), .CNT_W(3)) cmd_if ();

    shift_cmd_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd_if),
        .s1        (s1),
        .s0        (s0),
        .I_par     (i_par),
        .MSB_in    (msb_in),
        .LSB_in    (lsb_in),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Downstream universal shift register: 00 hold, 01 right, 10 left, 11 load.
    always_ff @(posedge clk) begin
        case ({s1, s0})
            2'b01:   a_q <= {msb_in, a_q[3:1]};
            2'b10:   a_q <= {a_q[2:0], lsb_in};
            2'b11:   a_q <= i_par;
            default: a_q <= a_q;
        endcase
    end

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  cnt;
        logic [3:0]  data;
        int          n;      // downstream actions expected
        logic [7:0]  ser;    // expected serial bit per action, index 0 first
        logic [31:0] exp_a;  // expected A after each action, nibble k = action k
        logic [3:0]  fin_a;  // expected A in the DONE cycle
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && cmd_if.cmd_ready !== 1'b1; i++) @(negedge clk);
        check("ready_wait", 32'(cmd_if.cmd_ready), 32'd1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_cnt   = cnt;
        cmd_if.cmd_data  = data;
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        wait_ready();
        issue(v.op, v.cnt, v.data);
        for (int k = 0; k < v.n; k++) begin
            check("run_s", 32'({s1, s0}), 32'(v.op));
            check("run_busy", 32'(busy), 32'd1);
            check("run_ready", 32'(cmd_if.cmd_ready), 32'd0);
            check("run_done", 32'(done), 32'd0);
            if (v.op == OP_LOAD) check("load_ipar", 32'(i_par), 32'(v.data));
            if (v.op == OP_SHR)  check("shr_msb_in", 32'(msb_in), 32'(v.ser[k]));
            if (v.op == OP_SHL)  check("shl_lsb_in", 32'(lsb_in), 32'(v.ser[k]));
            @(negedge clk);
            check("a_step", 32'(a_q), 32'(v.exp_a[k*4 +: 4]));
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_s_hold", 32'({s1, s0}), 32'd0);
        check("done_busy", 32'(busy), 32'd1);
        check("done_a", 32'(a_q), 32'(v.fin_a));
        @(negedge clk);
        check("after_done", 32'(done), 32'd0);
        check("after_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("after_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{OP_LOAD, 3'd0, 4'b1010, 1, 8'h00, 32'h0000000A, 4'b1010};
        tbl[1] = '{OP_SHR,  3'd2, 4'b0011, 2, 8'h03, 32'h000000ED, 4'b1110};
        tbl[2] = '{OP_LOAD, 3'd0, 4'b0000, 1, 8'h00, 32'h00000000, 4'b0000};
        tbl[3] = '{OP_SHL,  3'd3, 4'b1000, 3, 8'h01, 32'h00000421, 4'b0100};
        tbl[4] = '{OP_LOAD, 3'd0, 4'b0000, 1, 8'h00, 32'h00000000, 4'b0000};
        tbl[5] = '{OP_SHR,  3'd5, 4'b0001, 5, 8'h11, 32'h00081248, 4'b1000};
        tbl[6] = '{OP_SHL,  3'd0, 4'b1111, 0, 8'h00, 32'h00000000, 4'b1000};
        tbl[7] = '{OP_NOP,  3'd3, 4'b0101, 0, 8'h00, 32'h00000000, 4'b1000};
        tbl[8] = '{OP_SHL,  3'd7, 4'b0110, 7, 8'h66, 32'h039C6310, 4'b0011};

        rst              = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_NOP;
        cmd_if.cmd_cnt   = 3'd0;
        cmd_if.cmd_data  = 4'b0000;

        // Reset held for two cycles: every output stays low.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_outputs", 32'({cmd_if.cmd_ready, s1, s0, i_par, msb_in, lsb_in, busy, done}), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("release_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("release_busy", 32'(busy), 32'd0);
        check("release_state", 32'(state_dbg), 32'(ST_IDLE));

        for (int i = 0; i < 9; i++) run_vec(tbl[i]);

        // Reset on the second RUN cycle of SHR cnt=6, with a LOAD held on the channel.
        wait_ready();
        issue(OP_SHR, 3'd6, 4'b0101);
        check("mid_run1_s", 32'({s1, s0}), 32'(OP_SHR));
        @(negedge clk);
        check("mid_run2_s", 32'({s1, s0}), 32'(OP_SHR));
        rst              = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_LOAD;
        cmd_if.cmd_cnt   = 3'd0;
        cmd_if.cmd_data  = 4'b0110;
        @(negedge clk);
        check("mid_rst_s", 32'({s1, s0}), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_ready", 32'(cmd_if.cmd_ready), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("post_rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 cmd_if.cmd_valid = 1'b0;
        @(negedge clk);
        check("held_load_s", 32'({s1, s0}), 32'(OP_LOAD));
        check("held_load_ipar", 32'(i_par), 32'h6);
        @(negedge clk);
        check("held_load_done", 32'(done), 32'd1);
        check("held_load_a", 32'(a_q), 32'h6);
        @(negedge clk);
        check("held_load_ready", 32'(cmd_if.cmd_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
